ce_phase_monitor: RTL



---
 rtl/ce_phase_monitor_if.sv | 23 ++
 rtl/ce_phase_monitor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ce_phase_monitor_if.sv
// ce_phase_monitor_if
// Clock-enable strobe bundle produced by the clk24 clock generator.
//   master : the generator, drives every strobe
//   slave  : a consumer of the strobes, e.g. ce_phase_monitor
// Signals (all 1 bit, synchronous to clk24):
//   ce12, ce6, ce6x, ce3, video_slice, ce1m5, pipe_ab
interface ce_phase_monitor_if;
    logic ce12;
    logic ce6;
    logic ce6x;
    logic ce3;
    logic video_slice;
    logic ce1m5;
    logic pipe_ab;

    modport master (
        output ce12, ce6, ce6x, ce3, video_slice, ce1m5, pipe_ab
    );

    modport slave (
        input ce12, ce6, ce6x, ce3, video_slice, ce1m5, pipe_ab
    );
endinterface

// File: rtl/ce_phase_monitor.sv
// ce_phase_monitor
// Watches the clk24 clock-enable strobes. It rebuilds the generator's 6-bit
// phase from the pipe_ab rising edge and predicts every strobe on every
// cycle. It reports lock, the strobes that mismatched and a saturating
// error count.
// Ports:
//   clk24       in   only clock
//   reset       in   synchronous, active-high
//   ce_bus      in   strobe bundle (slave modport)
//   locked      out  tracking, with LOCK_PERIODS clean full periods seen
//   phase       out  reconstructed phase of the current sample
//   phase_valid out  phase is being tracked
//   err_pulse   out  one-cycle pulse per detected mismatch
//   err_mask    out  {pipe_ab, ce1m5, video_slice, ce3, ce6x, ce6, ce12}
//                    XOR of actual and expected at the last error
//   err_count   out  saturating mismatch count
module ce_phase_monitor #(
    parameter int LOCK_PERIODS = 4,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                 clk24,
    input  logic                 reset,
    ce_phase_monitor_if.slave    ce_bus,
    output logic                 locked,
    output logic [5:0]           phase,
    output logic                 phase_valid,
    output logic                 err_pulse,
    output logic [6:0]           err_mask,
    output logic [ERR_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_PERIODS);

    state_t                 state_reg;
    logic [5:0]             phase_reg;
    logic                   phase_valid_reg;
    logic                   locked_reg;
    logic                   err_pulse_reg;
    logic [6:0]             err_mask_reg;
    logic [ERR_WIDTH-1:0]   err_count_reg;
    logic [3:0]             clean_ctr_reg;
    logic                   period_full_reg;   // set once the partial first period has ended
    logic                   pipe_ab_prev_reg;
    logic                   armed_reg;         // a valid previous pipe_ab sample exists

    logic [5:0]             phase_next;
    logic [6:0]             actual_strobes;
    logic [6:0]             expected_strobes;
    logic [6:0]             diff_strobes;
    logic                   pipe_ab_rise;

    // The registered phase belongs to the previous sample, so the sample
    // now at the inputs is checked against phase_reg + 1.
    always_comb begin
        phase_next       = phase_reg + 6'd1;
        actual_strobes   = {ce_bus.pipe_ab, ce_bus.ce1m5, ce_bus.video_slice,
                            ce_bus.ce3, ce_bus.ce6x, ce_bus.ce6, ce_bus.ce12};
        expected_strobes = {phase_next[5],
                            (phase_next[3:0] == 4'd6),
                            ~phase_next[2],
                            (phase_next[2:0] == 3'd6),
                            phase_next[1] & ~phase_next[0],
                            phase_next[1] & phase_next[0],
                            phase_next[0]};
        // The first sample after reset has no valid predecessor, so a
        // pipe_ab that is already high there is not treated as an edge.
        pipe_ab_rise     = armed_reg & ~pipe_ab_prev_reg & ce_bus.pipe_ab;
    end

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_diff
            assign diff_strobes[gi] = actual_strobes[gi] ^ expected_strobes[gi];
        end
    endgenerate

    always_ff @(posedge clk24) begin
        if (reset) begin
            state_reg        <= ACQUIRE;
            phase_reg        <= 6'd0;
            phase_valid_reg  <= 1'b0;
            locked_reg       <= 1'b0;
            err_pulse_reg    <= 1'b0;
            err_mask_reg     <= 7'd0;
            err_count_reg    <= '0;
            clean_ctr_reg    <= 4'd0;
            period_full_reg  <= 1'b0;
            pipe_ab_prev_reg <= 1'b0;
            armed_reg        <= 1'b0;
        end else begin
            pipe_ab_prev_reg <= ce_bus.pipe_ab;
            armed_reg        <= 1'b1;
            err_pulse_reg    <= 1'b0;
            case (state_reg)
                ACQUIRE: begin
                    if (pipe_ab_rise) begin
                        state_reg       <= TRACK;
                        phase_reg       <= 6'd32;
                        phase_valid_reg <= 1'b1;
                        clean_ctr_reg   <= 4'd0;
                        period_full_reg <= 1'b0;
                    end
                end
                TRACK, LOCKED: begin
                    if (|diff_strobes) begin
                        // Any rising edge in this same sample is ignored:
                        // ACQUIRE only looks at the following samples.
                        state_reg       <= ACQUIRE;
                        err_pulse_reg   <= 1'b1;
                        err_mask_reg    <= diff_strobes;
                        if (err_count_reg != '1)
                            err_count_reg <= err_count_reg + ERR_WIDTH'(1);
                        clean_ctr_reg   <= 4'd0;
                        locked_reg      <= 1'b0;
                        phase_valid_reg <= 1'b0;
                    end else begin
                        phase_reg <= phase_next;
                        if (phase_next == 6'd0) begin
                            // The wrap that ends the partial period started at
                            // acquisition (phase 32) is not counted as clean.
                            if (!period_full_reg) begin
                                period_full_reg <= 1'b1;
                            end else if (state_reg == TRACK) begin
                                clean_ctr_reg <= clean_ctr_reg + 4'd1;
                                if (clean_ctr_reg + 4'd1 == LOCK_TARGET) begin
                                    state_reg  <= LOCKED;
                                    locked_reg <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ACQUIRE;
                end
            endcase
        end
    end

    assign locked      = locked_reg;
    assign phase       = phase_reg;
    assign phase_valid = phase_valid_reg;
    assign err_pulse   = err_pulse_reg;
    assign err_mask    = err_mask_reg;
    assign err_count   = err_count_reg;

endmodule
